b1_tlm_rx: RTL and testbench

UART telemetry frame receiver for the B1 link. It is the receiving end of the serial telemetry stream that the B1 UART block emits for each tracking channel (BOC, TMBOC): carrier NCO, code NCO, code phase, and prompt I/Q accumulators. The block deserialises 8N1 bytes, hunts for the frame header, checks the checksum, and presents the decoded fields with a one-cycle valid strobe. It is used in loopback/self-test builds and on the host-side monitor FPGA.

---
 rtl/b1_tlm_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_b1_tlm_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b1_tlm_rx.sv
// rtl/b1_tlm_rx.sv - B1 telemetry UART frame receiver (8N1 deserialiser, header hunt, checksum check)
// Optional inter-byte gap timeout is built when B1_TLM_RX_TIMEOUT_EN is defined.
module b1_tlm_rx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HDR0         = 8'hEB,
  parameter logic [7:0]  HDR1         = 8'h90,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic        rx_uart,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  output logic [7:0]  tx_chan,
  output logic [31:0] tx_car_nco,
  output logic [31:0] tx_prn_nco,
  output logic [11:0] tx_prn_phs,
  output logic [23:0] tx_bbP_real,
  output logic [23:0] tx_bbP_imag,
  output logic        tx_frame_valid,
  output logic        tx_csum_err,
  output logic        tx_fram_err,
  output logic [15:0] tx_frame_cnt
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [2:0] {P_HUNT0, P_HUNT1, P_CHAN, P_PAYLOAD, P_CSUM} pstate_t;

  logic          sync1_q, sync2_q;
  bstate_t       bs_q, bs_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_done, stop_bad, tmo_fire;

  pstate_t       ps_q, ps_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    idx_q, idx_d;
  logic [127:0]  stage_q, stage_d;
  logic [7:0]    chan_q, chan_d;
  logic          frame_ok, csum_bad;

  logic [7:0]  tx_byte_q, tx_chan_q;
  logic        tx_byte_valid_q, tx_frame_valid_q, tx_csum_err_q, tx_fram_err_q;
  logic [31:0] tx_car_nco_q, tx_prn_nco_q;
  logic [11:0] tx_prn_phs_q;
  logic [23:0] tx_bbP_real_q, tx_bbP_imag_q;
  logic [15:0] tx_frame_cnt_q;

  always_comb begin
    bs_d      = bs_q;
    bcnt_d    = bcnt_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (bs_q)
      B_IDLE: begin
        bcnt_d = '0;
        if (!sync2_q) bs_d = B_START;
      end
      B_START: begin
        if (bcnt_q == HALF) begin
          bcnt_d = '0;
          bidx_d = 3'd0;
          bs_d   = sync2_q ? B_IDLE : B_DATA;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (bcnt_q == FULL) begin
          bcnt_d  = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) bs_d = B_STOP;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      B_STOP: begin
        // Leave at the stop-bit midpoint so a back-to-back start bit is caught.
        if (bcnt_q == FULL) begin
          bcnt_d    = '0;
          bs_d      = B_IDLE;
          byte_done = sync2_q;
          stop_bad  = !sync2_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: bs_d = B_IDLE;
    endcase
  end

  always_comb begin
    ps_d     = ps_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    chan_d   = chan_q;
    frame_ok = 1'b0;
    csum_bad = 1'b0;
    if (stop_bad || tmo_fire) begin
      ps_d = P_HUNT0;
    end else if (tx_byte_valid_q) begin
      unique case (ps_q)
        P_HUNT0: if (tx_byte_q == HDR0) ps_d = P_HUNT1;
        P_HUNT1: begin
          if (tx_byte_q == HDR1)      ps_d = P_CHAN;
          else if (tx_byte_q == HDR0) ps_d = P_HUNT1;
          else                        ps_d = P_HUNT0;
        end
        P_CHAN: begin
          if (tx_byte_q == 8'h01 || tx_byte_q == 8'h02) begin
            ps_d   = P_PAYLOAD;
            sum_d  = tx_byte_q;
            idx_d  = 4'd0;
            chan_d = tx_byte_q;
          end else begin
            ps_d = P_HUNT0;
          end
        end
        P_PAYLOAD: begin
          stage_d = {stage_q[119:0], tx_byte_q};
          sum_d   = sum_q + tx_byte_q;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd15) ps_d = P_CSUM;
        end
        P_CSUM: begin
          frame_ok = (tx_byte_q == sum_q);
          csum_bad = (tx_byte_q != sum_q);
          ps_d     = P_HUNT0;
        end
        default: ps_d = P_HUNT0;
      endcase
    end
  end

`ifdef B1_TLM_RX_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);
  logic [31:0] gap_q;

  assign tmo_fire = (ps_q != P_HUNT0) && !tx_byte_valid_q && (gap_q == TMO_LIMIT - 32'd1);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n)                                          gap_q <= '0;
    else if (tx_byte_valid_q || ps_q == P_HUNT0 || tmo_fire) gap_q <= '0;
    else                                                    gap_q <= gap_q + 32'd1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync1_q          <= 1'b1;
      sync2_q          <= 1'b1;
      bs_q             <= B_IDLE;
      bcnt_q           <= '0;
      bidx_q           <= '0;
      shreg_q          <= '0;
      ps_q             <= P_HUNT0;
      sum_q            <= '0;
      idx_q            <= '0;
      stage_q          <= '0;
      chan_q           <= '0;
      tx_byte_q        <= '0;
      tx_byte_valid_q  <= 1'b0;
      tx_chan_q        <= '0;
      tx_car_nco_q     <= '0;
      tx_prn_nco_q     <= '0;
      tx_prn_phs_q     <= '0;
      tx_bbP_real_q    <= '0;
      tx_bbP_imag_q    <= '0;
      tx_frame_valid_q <= 1'b0;
      tx_csum_err_q    <= 1'b0;
      tx_fram_err_q    <= 1'b0;
      tx_frame_cnt_q   <= '0;
    end else begin
      sync1_q          <= rx_uart;
      sync2_q          <= sync1_q;
      bs_q             <= bs_d;
      bcnt_q           <= bcnt_d;
      bidx_q           <= bidx_d;
      shreg_q          <= shreg_d;
      ps_q             <= ps_d;
      sum_q            <= sum_d;
      idx_q            <= idx_d;
      stage_q          <= stage_d;
      chan_q           <= chan_d;
      tx_byte_valid_q  <= byte_done;
      tx_frame_valid_q <= frame_ok;
      tx_csum_err_q    <= csum_bad;
      tx_fram_err_q    <= stop_bad | tmo_fire;
      if (byte_done) tx_byte_q <= shreg_q;
      if (frame_ok) begin
        tx_chan_q      <= chan_q;
        tx_car_nco_q   <= stage_q[127:96];
        tx_prn_nco_q   <= stage_q[95:64];
        tx_prn_phs_q   <= stage_q[59:48];
        tx_bbP_real_q  <= stage_q[47:24];
        tx_bbP_imag_q  <= stage_q[23:0];
        tx_frame_cnt_q <= tx_frame_cnt_q + 16'd1;
      end
    end
  end

  assign tx_byte        = tx_byte_q;
  assign tx_byte_valid  = tx_byte_valid_q;
  assign tx_chan        = tx_chan_q;
  assign tx_car_nco     = tx_car_nco_q;
  assign tx_prn_nco     = tx_prn_nco_q;
  assign tx_prn_phs     = tx_prn_phs_q;
  assign tx_bbP_real    = tx_bbP_real_q;
  assign tx_bbP_imag    = tx_bbP_imag_q;
  assign tx_frame_valid = tx_frame_valid_q;
  assign tx_csum_err    = tx_csum_err_q;
  assign tx_fram_err    = tx_fram_err_q;
  assign tx_frame_cnt   = tx_frame_cnt_q;

endmodule

// File: tb/tb_b1_tlm_rx.sv
// tb/tb_b1_tlm_rx.sv - directed scoreboard bench for b1_tlm_rx
// Timeout step is included when B1_TLM_RX_TIMEOUT_EN is defined.
module tb_b1_tlm_rx;
  localparam int CPB = 16;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  logic        rx_uart = 1'b1;
  logic [7:0]  tx_byte, tx_chan;
  logic        tx_byte_valid, tx_frame_valid, tx_csum_err, tx_fram_err;
  logic [31:0] tx_car_nco, tx_prn_nco;
  logic [11:0] tx_prn_phs;
  logic [23:0] tx_bbP_real, tx_bbP_imag;
  logic [15:0] tx_frame_cnt;

  b1_tlm_rx #(.CLKS_PER_BIT(CPB)) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_uart(rx_uart),
    .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_chan(tx_chan),
    .tx_car_nco(tx_car_nco), .tx_prn_nco(tx_prn_nco), .tx_prn_phs(tx_prn_phs),
    .tx_bbP_real(tx_bbP_real), .tx_bbP_imag(tx_bbP_imag),
    .tx_frame_valid(tx_frame_valid), .tx_csum_err(tx_csum_err),
    .tx_fram_err(tx_fram_err), .tx_frame_cnt(tx_frame_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [7:0]  chan;
    logic [31:0] car, prn;
    logic [11:0] phs;
    logic [23:0] re, im;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  int          n_fv = 0, n_csum = 0, n_fram = 0, n_bv = 0;
  int          cyc = 0, last_bv_cyc = 0;
  logic [7:0]  fb [20];
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  cur_chan;
  logic [31:0] cur_car, cur_prn;
  logic [15:0] cur_phs;
  logic [23:0] cur_re, cur_im;

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(negedge rx_clk) begin
    exp_t e;
    if (tx_byte_valid) begin n_bv++; last_bv_cyc = cyc; end
    if (tx_csum_err) n_csum++;
    if (tx_fram_err) n_fram++;
    if (tx_frame_valid) begin
      n_fv++;
      chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      chk("frame_latency", 32'(cyc - last_bv_cyc), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_chan", 32'(tx_chan), 32'(e.chan));
        chk("sb_car",  tx_car_nco, e.car);
        chk("sb_prn",  tx_prn_nco, e.prn);
        chk("sb_phs",  32'(tx_prn_phs), 32'(e.phs));
        chk("sb_re",   32'(tx_bbP_real), 32'(e.re));
        chk("sb_im",   32'(tx_bbP_imag), 32'(e.im));
        chk("sb_cnt",  32'(tx_frame_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic build(input logic [7:0] chan, input logic [31:0] car, input logic [31:0] prn,
                       input logic [15:0] phs, input logic [23:0] re, input logic [23:0] im,
                       input logic [7:0] delta);
    logic [7:0] s;
    cur_chan = chan; cur_car = car; cur_prn = prn; cur_phs = phs; cur_re = re; cur_im = im;
    fb[0] = 8'hEB; fb[1] = 8'h90; fb[2] = chan;
    for (int i = 0; i < 4; i++) fb[3 + i] = car[31 - 8*i -: 8];
    for (int i = 0; i < 4; i++) fb[7 + i] = prn[31 - 8*i -: 8];
    fb[11] = phs[15:8]; fb[12] = phs[7:0];
    for (int i = 0; i < 3; i++) fb[13 + i] = re[23 - 8*i -: 8];
    for (int i = 0; i < 3; i++) fb[16 + i] = im[23 - 8*i -: 8];
    s = 8'd0;
    for (int i = 2; i < 19; i++) s = s + fb[i];
    fb[19] = s + delta;
  endtask

  task automatic build_rand();
    build(($urandom_range(0, 1) != 0) ? 8'h02 : 8'h01, $urandom, $urandom,
          16'($urandom), 24'($urandom), 24'($urandom), 8'd0);
  endtask

  task automatic push_exp();
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.chan = cur_chan; e.car = cur_car; e.prn = cur_prn; e.phs = cur_phs[11:0];
    e.re = cur_re; e.im = cur_im; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_uart = 1'b0;
    repeat (CPB) @(negedge rx_clk);
    for (int i = 0; i < 8; i++) begin
      rx_uart = b[i];
      repeat (CPB) @(negedge rx_clk);
    end
    rx_uart = stop;
    repeat (CPB) @(negedge rx_clk);
    rx_uart = 1'b1;
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i <= upto; i++) send_byte(fb[i], 1'b1);
  endtask

  task automatic idle_bits(input int bits);
    rx_uart = 1'b1;
    repeat (bits * CPB) @(negedge rx_clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge rx_clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int bv0, fv0, fr0, cs0;
    repeat (5) @(negedge rx_clk);
    rx_rst_n = 1'b1;
    repeat (3) @(negedge rx_clk);

    chk("rst_byte", 32'(tx_byte), 32'd0);
    chk("rst_byte_valid", 32'(tx_byte_valid), 32'd0);
    chk("rst_chan", 32'(tx_chan), 32'd0);
    chk("rst_car", tx_car_nco, 32'd0);
    chk("rst_frame_valid", 32'(tx_frame_valid), 32'd0);
    chk("rst_errs", 32'({tx_csum_err, tx_fram_err}), 32'd0);
    chk("rst_cnt", 32'(tx_frame_cnt), 32'd0);

    // Bad checksum first: outputs must stay at reset values.
    build(8'h01, 32'h12345678, 32'h0A0B0C0D, 16'h0ABC, 24'h7FFFFF, 24'h800000, 8'd1);
    bv0 = n_bv;
    send_range(0, 19);
    idle_bits(2);
    chk("bad_csum_err", 32'(n_csum), 32'd1);
    chk("bad_csum_no_fv", 32'(n_fv), 32'd0);
    chk("bad_csum_bytes", 32'(n_bv - bv0), 32'd20);
    chk("bad_csum_car", tx_car_nco, 32'd0);
    chk("bad_csum_im", 32'(tx_bbP_imag), 32'd0);
    chk("bad_csum_cnt", 32'(tx_frame_cnt), 32'd0);

    build(8'h01, 32'h12345678, 32'h0A0B0C0D, 16'h0ABC, 24'h7FFFFF, 24'h800000, 8'd0);
    push_exp();
    send_range(0, 19);
    drain("good_decoded");
    chk("good_chan", 32'(tx_chan), 32'h01);
    chk("good_car", tx_car_nco, 32'h12345678);
    chk("good_phs", 32'(tx_prn_phs), 32'hABC);
    chk("good_im", 32'(tx_bbP_imag), 32'h800000);
    chk("good_cnt", 32'(tx_frame_cnt), 32'd1);
    chk("good_last_byte", 32'(tx_byte), 32'(fb[19]));
    chk("good_no_csum_err", 32'(n_csum), 32'd1);

    build_rand();
    push_exp();
    send_byte(8'h55, 1'b1); send_byte(8'hEB, 1'b1); send_byte(8'hEB, 1'b1); send_byte(8'h90, 1'b1);
    send_range(2, 19);
    drain("resync_decoded");

    fv0 = n_fv;
    build(8'h03, 32'h12345678, 32'h0A0B0C0D, 16'h0ABC, 24'h7FFFFF, 24'h800000, 8'd0);
    send_range(0, 19);
    build_rand();
    push_exp();
    send_range(0, 19);
    drain("chan3_then_good");
    chk("chan3_one_frame", 32'(n_fv - fv0), 32'd1);

    fv0 = n_fv; fr0 = n_fram;
    build(8'h01, 32'h12345678, 32'h0A0B0C0D, 16'h0ABC, 24'h7FFFFF, 24'h800000, 8'd0);
    send_range(0, 7);
    send_byte(fb[8], 1'b0);
    idle_bits(12);
    send_range(9, 19);
    chk("stop0_fram_err", 32'(n_fram - fr0), 32'd1);
    chk("stop0_no_frame", 32'(n_fv - fv0), 32'd0);
    build_rand();
    push_exp();
    send_range(0, 19);
    drain("stop0_next_good");

    bv0 = n_bv; fr0 = n_fram;
    rx_uart = 1'b0;
    repeat (5) @(negedge rx_clk);
    idle_bits(3);
    chk("glitch_no_byte", 32'(n_bv - bv0), 32'd0);
    chk("glitch_no_err", 32'(n_fram - fr0), 32'd0);

    build_rand();
    send_range(0, 9);
    rx_rst_n = 1'b0;
    repeat (3) @(negedge rx_clk);
    rx_rst_n = 1'b1;
    exp_cnt = 16'd0;
    repeat (2) @(negedge rx_clk);
    chk("midrst_chan", 32'(tx_chan), 32'd0);
    chk("midrst_car", tx_car_nco, 32'd0);
    chk("midrst_prn", tx_prn_nco, 32'd0);
    chk("midrst_phs", 32'(tx_prn_phs), 32'd0);
    chk("midrst_re_im", 32'({tx_bbP_real[7:0], tx_bbP_imag}), 32'd0);
    chk("midrst_cnt", 32'(tx_frame_cnt), 32'd0);
    chk("midrst_byte", 32'(tx_byte), 32'd0);
    build_rand();
    push_exp();
    send_range(0, 19);
    drain("midrst_next_good");
    chk("midrst_cnt_after", 32'(tx_frame_cnt), 32'd1);

`ifdef B1_TLM_RX_TIMEOUT_EN
    fr0 = n_fram; fv0 = n_fv;
    build_rand();
    send_range(0, 7);
    idle_bits(21);
    chk("tmo_fram_err", 32'(n_fram - fr0), 32'd1);
    chk("tmo_no_frame", 32'(n_fv - fv0), 32'd0);
    build_rand();
    push_exp();
    send_range(0, 19);
    drain("tmo_next_good");
`endif

    cs0 = n_csum;
    idle_bits(2);
    chk("final_no_extra_csum", 32'(n_csum - cs0), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
